axis_bram_sched: RTL and testbench
==================================

AXIS_BRAM_SCHED -- requirements
Module: axis_bram_sched

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 12, width of BRAM word addresses.
REQ-002 SHALL have parameter BEATS_PER_WORD, default 36, the number of 32-bit stream beats per 1152-bit BRAM word.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the idle-beat watchdog limit.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- aclk  in  1  sole clock; one clock, all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  requester N (N=0,1) has a descriptor.
- reqN_ready  out  1  descriptor N accepted this cycle.
- reqN_rw  in  1  1 = stream-to-BRAM write, 0 = BRAM-to-stream read.
- reqN_start  in  ADDR_WIDTH  first word address.
- reqN_bound  in  ADDR_WIDTH  last word address, inclusive.
- reqN_done  out  1  one-cycle job-complete pulse to requester N.
- err  out  1  qualifies reqN_done: job failed.
- busy  out  1  a job is in flight.
- rw  out  1  adapter direction.
- addr_reload  out  1  adapter address-load strobe.
- bram_start_addr  out  ADDR_WIDTH  adapter start address.
- bram_bound_addr  out  ADDR_WIDTH  adapter bound address.
- s_beat, s_last  in  1  monitor of adapter input stream: tvalid&tready, and tlast.
- m_beat, m_last  in  1  monitor of adapter output stream: tvalid&tready, and tlast.

Function
REQ-005 SHALL implement states IDLE, LOAD, RUN and DONE.
REQ-006 In IDLE, if at least one reqN_valid is high, SHALL assert exactly one reqN_ready for one cycle, latch that descriptor, and go to LOAD.
REQ-007 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not granted last; after reset, requester 0 has priority.
REQ-008 In LOAD, SHALL drive addr_reload=1 for exactly one cycle, with rw, bram_start_addr and bram_bound_addr already carrying the latched values, then go to RUN.
REQ-009 rw, bram_start_addr and bram_bound_addr SHALL be held stable from LOAD until DONE is exited.
REQ-010 In RUN, SHALL count beats in an 18-bit counter, using s_beat when rw=1 and m_beat when rw=0; the other stream SHALL be ignored.
REQ-011 RUN SHALL end on a counted beat with the matching last (s_last or m_last).
REQ-012 At the end of RUN, the expected beat count SHALL be (bound-start+1)*BEATS_PER_WORD, computed at full width without truncation.
REQ-013 err SHALL be set if the actual beat count differs from the expected count.
REQ-014 DONE SHALL last one cycle, pulse reqN_done (with err) for the granted requester, then return to IDLE; a new grant is possible on the following cycle.
REQ-015 A descriptor with bound < start SHALL be accepted, produce no addr_reload, and go directly to DONE with err=1.
REQ-016 busy SHALL be high in LOAD, RUN and DONE.
REQ-017 Beats and last flags arriving in IDLE SHALL be ignored.
REQ-018 reqN_valid dropping after acceptance SHALL have no effect on the job.

Reset
REQ-019 While areset is high, SHALL return immediately, including mid-job, to IDLE.
REQ-020 Reset values SHALL be: all outputs 0, beat counter 0, round-robin pointer favouring requester 0.
REQ-021 An aborted job SHALL produce no reqN_done.

Configuration
REQ-022 The macro SCHED_TIMEOUT_EN SHALL select the watchdog.
REQ-023 When SCHED_TIMEOUT_EN is defined, TIMEOUT_CYCLES consecutive RUN cycles without a counted beat SHALL force DONE with err=1 and reset the watchdog count.
REQ-024 When SCHED_TIMEOUT_EN is undefined, SHALL include no watchdog logic, and RUN SHALL wait indefinitely.

Verification
REQ-025 req0 read {start 6, bound 7}, 72 m_beats with m_last on the 72nd -> addr_reload one cycle after req0_ready; req0_done two cycles after the last beat; err=0.
REQ-026 req1 write {start 3, bound 7}, s_last on beat 100 -> req1_done with err=1 (expected 180).
REQ-027 req0 and req1 valid together, twice back-to-back -> grants in order 0,1,0,1; each done pulse goes only to its own requester.
REQ-028 Descriptor {start 9, bound 2} -> no addr_reload; done with err=1 within two cycles of acceptance.
REQ-029 areset asserted mid-RUN after 10 beats -> all outputs 0 immediately; no done pulse; the next job runs normally.
REQ-030 With SCHED_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, a job with no beats -> done with err=1 after 16 RUN cycles; with the macro undefined, busy stays high.

Source files
------------

// File: rtl/axis_bram_sched.sv
// Job scheduler for an AXI-Stream <-> BRAM width adapter: arbitrates two descriptor
// requesters, loads the adapter, counts stream beats and reports completion/error.
// Optional idle-beat watchdog enabled by defining SCHED_TIMEOUT_EN.
module axis_bram_sched #(
  parameter int ADDR_WIDTH     = 12,
  parameter int BEATS_PER_WORD = 36,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_rw,
  input  logic [ADDR_WIDTH-1:0] req0_start,
  input  logic [ADDR_WIDTH-1:0] req0_bound,
  output logic                  req0_done,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_rw,
  input  logic [ADDR_WIDTH-1:0] req1_start,
  input  logic [ADDR_WIDTH-1:0] req1_bound,
  output logic                  req1_done,
  output logic                  err,
  output logic                  busy,
  output logic                  rw,
  output logic                  addr_reload,
  output logic [ADDR_WIDTH-1:0] bram_start_addr,
  output logic [ADDR_WIDTH-1:0] bram_bound_addr,
  input  logic                  s_beat,
  input  logic                  s_last,
  input  logic                  m_beat,
  input  logic                  m_last
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int CNT_W = 18;
  localparam int EXP_W = ADDR_WIDTH + 1 + $clog2(BEATS_PER_WORD + 1);
  localparam int CMP_W = (EXP_W > CNT_W) ? EXP_W : CNT_W;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;     // 1 = requester 1 wins a tie
  logic                  gnt_q, gnt_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH-1:0] bound_q, bound_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic                  err_q, err_d;
  logic                  ready0_c, ready1_c;
  logic                  reload_c;

  logic                  run_beat, run_last;
  logic                  pick1;
  logic                  sel_rw;
  logic [ADDR_WIDTH-1:0] sel_start, sel_bound;
  logic [ADDR_WIDTH:0]   span;
  logic [CMP_W-1:0]      exp_beats;
  logic                  timeout_hit;
  logic                  timeout_seen;

  assign run_beat  = (state_q == RUN) && (rw_q ? s_beat : m_beat);
  assign run_last  = rw_q ? s_last : m_last;
  assign pick1     = req1_valid && (!req0_valid || prio_q);
  assign sel_rw    = pick1 ? req1_rw    : req0_rw;
  assign sel_start = pick1 ? req1_start : req0_start;
  assign sel_bound = pick1 ? req1_bound : req0_bound;

  // Span is one bit wider than an address so a full-range job cannot wrap.
  assign span      = {1'b0, bound_q} - {1'b0, start_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign exp_beats = CMP_W'(span) * CMP_W'(BEATS_PER_WORD);

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;

  always_comb begin
    wd_d        = wd_q;
    to_d        = to_q;
    timeout_hit = 1'b0;
    if (state_q == IDLE) begin
      wd_d = '0;
      to_d = 1'b0;
    end else if (state_q == RUN) begin
      if (run_beat) begin
        wd_d = '0;
      end else if (wd_q == WD_MAX) begin
        wd_d        = '0;
        to_d        = 1'b1;
        timeout_hit = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign timeout_seen = to_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_seen = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    gnt_d    = gnt_q;
    rw_d     = rw_q;
    start_d  = start_q;
    bound_d  = bound_q;
    cnt_d    = cnt_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err_d    = 1'b0;
    ready0_c = 1'b0;
    ready1_c = 1'b0;
    reload_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          ready0_c = !pick1;
          ready1_c = pick1;
          gnt_d    = pick1;
          prio_d   = !pick1;
          rw_d     = sel_rw;
          start_d  = sel_start;
          bound_d  = sel_bound;
          cnt_d    = '0;
          // An inverted range never touches the adapter.
          state_d  = (sel_bound < sel_start) ? DONE : LOAD;
        end
      end
      LOAD: begin
        reload_c = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (run_beat) begin
          // Saturate so a runaway stream cannot wrap back onto the expected count.
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (run_last) state_d = DONE;
        end
        if (timeout_hit) state_d = DONE;
      end
      DONE: begin
        done0_d = !gnt_q;
        done1_d = gnt_q;
        err_d   = (bound_q < start_q) || timeout_seen ||
                  (CMP_W'(cnt_q) != exp_beats);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      rw_q    <= 1'b0;
      start_q <= '0;
      bound_q <= '0;
      cnt_q   <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      rw_q    <= rw_d;
      start_q <= start_d;
      bound_q <= bound_d;
      cnt_q   <= cnt_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
    end
  end

  // Ready is decoded from IDLE, which reset also forces, so gate it to stay low in reset.
  assign req0_ready      = ready0_c && !areset;
  assign req1_ready      = ready1_c && !areset;
  assign req0_done       = done0_q;
  assign req1_done       = done1_q;
  assign err             = err_q;
  assign busy            = (state_q != IDLE);
  assign rw              = rw_q;
  assign addr_reload     = reload_c;
  assign bram_start_addr = start_q;
  assign bram_bound_addr = bound_q;

endmodule

// File: tb/tb_axis_bram_sched.sv
// Scoreboard bench for axis_bram_sched: directed scenarios plus randomized jobs checked
// against a behavioural model of arbitration and beat-count error rules.
module tb_axis_bram_sched;

  localparam int AW  = 12;
  localparam int BPW = 36;
  localparam int TO  = 16;

  typedef struct {
    int id;
    bit err;
  } exp_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          v[2];
  logic          rwv[2];
  logic [AW-1:0] st[2];
  logic [AW-1:0] bd[2];
  int            nb[2];
  logic          r0, r1, d0, d1, err, busy, rw, addr_reload;
  logic [AW-1:0] bsa, bba;
  logic          s_beat, s_last, m_beat, m_last;

  int   checks   = 0;
  int   failures = 0;
  int   prio     = 0;
  exp_t sbq[$];

  axis_bram_sched #(
    .ADDR_WIDTH(AW), .BEATS_PER_WORD(BPW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req0_valid(v[0]), .req0_ready(r0), .req0_rw(rwv[0]),
    .req0_start(st[0]), .req0_bound(bd[0]), .req0_done(d0),
    .req1_valid(v[1]), .req1_ready(r1), .req1_rw(rwv[1]),
    .req1_start(st[1]), .req1_bound(bd[1]), .req1_done(d1),
    .err(err), .busy(busy), .rw(rw), .addr_reload(addr_reload),
    .bram_start_addr(bsa), .bram_bound_addr(bba),
    .s_beat(s_beat), .s_last(s_last), .m_beat(m_beat), .m_last(m_last)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: inverted range fails; otherwise beats must equal words * BPW.
  function automatic bit model_err(input logic [AW-1:0] s, input logic [AW-1:0] b, input int n);
    if (b < s) return 1'b1;
    return n != (int'(b) - int'(s) + 1) * BPW;
  endfunction

  task automatic set_req(input int i, input bit r, input int s, input int b, input int n);
    rwv[i] = r;
    st[i]  = s[AW-1:0];
    bd[i]  = b[AW-1:0];
    nb[i]  = n;
  endtask

  task automatic clear_beats();
    s_beat = 1'b0; s_last = 1'b0; m_beat = 1'b0; m_last = 1'b0;
  endtask

  task automatic drive_beat(input bit sel_s, input bit b, input bit l);
    if (sel_s) begin
      s_beat = b; s_last = l; m_beat = 1'($urandom); m_last = 1'($urandom);
    end else begin
      m_beat = b; m_last = l; s_beat = 1'($urandom); s_last = 1'($urandom);
    end
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      s_beat = 1'($urandom); s_last = 1'($urandom);
      m_beat = 1'($urandom); m_last = 1'($urandom);
    end
    @(negedge aclk);
    clear_beats();
  endtask

  // Waits for a grant on the upcoming edge; returns at the negedge after it.
  task automatic wait_grant(output int w);
    int   n;
    int   we;
    exp_t e;
    w = -1;
    n = 0;
    #1;
    while (!(r0 || r1) && n < 20) begin
      @(negedge aclk); #1; n++;
    end
    check("grant_seen", {31'b0, r0 | r1}, 1);
    if (!(r0 || r1)) return;
    check("one_ready", {31'b0, r0 & r1}, 0);
    we = (v[0] && v[1]) ? prio : (v[0] ? 0 : 1);
    w  = r1 ? 1 : 0;
    check("grant_id", w, we);
    prio  = 1 - we;
    e.id  = we;
    e.err = model_err(st[we], bd[we], nb[we]);
    sbq.push_back(e);
    @(negedge aclk);
    v[w] = 1'b0;
  endtask

  task automatic run_job(input int w);
    bit bad;
    int k;
    bad = bd[w] < st[w];
    #1;
    check("busy_after_grant", {31'b0, busy}, 1);
    check("addr_reload", {31'b0, addr_reload}, {31'b0, !bad});
    if (!bad) begin
      check("rw_out", {31'b0, rw}, {31'b0, rwv[w]});
      check("start_out", bsa, st[w]);
      check("bound_out", bba, bd[w]);
      k = 0;
      while (k < nb[w]) begin
        @(negedge aclk);
        if ($urandom_range(0, 3) == 0) drive_beat(rwv[w], 1'b0, 1'($urandom));
        else begin
          drive_beat(rwv[w], 1'b1, k == nb[w] - 1);
          k++;
        end
      end
      @(negedge aclk);
      clear_beats();
      #1;
      check("busy_in_done", {31'b0, busy}, 1);
      check("hold_start", bsa, st[w]);
    end
    @(negedge aclk); #1;
    check("done_pulse", {31'b0, (w == 1) ? d1 : d0}, 1);
  endtask

  task automatic abort_job();
    void'(sbq.pop_back());
    prio = 0;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding job.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk); #2;
      if (d0 || d1) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got d0=%0b d1=%0b with no job outstanding", d0, d1);
        end else begin
          e = sbq.pop_front();
          check("done_one_hot", {31'b0, d0 & d1}, 0);
          check("done_id", {31'b0, d1}, e.id);
          check("done_err", {31'b0, err}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int  w, s, b, ex, n;
    int  mask;
    bit  seen;
    areset = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0;
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    clear_beats();
    repeat (3) @(negedge aclk);
    #1;
    check("reset_ctrl", {24'b0, r0, r1, d0, d1, err, busy, rw, addr_reload}, 0);
    check("reset_addr", {8'b0, bsa, bba}, 0);
    @(negedge aclk);
    areset = 1'b0;

    // Read job with matching count.
    idle_noise(3);
    set_req(0, 1'b0, 6, 7, 72); v[0] = 1'b1;
    wait_grant(w); run_job(w);

    // Write job with short count.
    set_req(1, 1'b1, 3, 7, 100); v[1] = 1'b1;
    wait_grant(w); run_job(w);

    // Contention, twice back to back: 0,1,0,1.
    for (int r = 0; r < 2; r++) begin
      set_req(0, 1'b0, 1, 1, 36);
      set_req(1, 1'b1, 2, 3, 72 - r);
      v[0] = 1'b1; v[1] = 1'b1;
      wait_grant(w); run_job(w);
      wait_grant(w); run_job(w);
    end

    // Inverted range.
    set_req(0, 1'b1, 9, 2, 0); v[0] = 1'b1;
    wait_grant(w); run_job(w);

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      idle_noise($urandom_range(0, 3));
      mask = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        if (mask[i]) begin
          s = $urandom_range(4, 40);
          if ($urandom_range(0, 5) == 0) b = s - $urandom_range(1, 4);
          else b = s + $urandom_range(0, 3);
          ex = (b >= s) ? (b - s + 1) * BPW : 0;
          if (b < s) n = 0;
          else if ($urandom_range(0, 1) == 0) n = ex;
          else n = $urandom_range(1, ex + 10);
          set_req(i, 1'($urandom), s, b, n);
          v[i] = 1'b1;
        end
      end
      wait_grant(w);
      v[0] = 1'b0; v[1] = 1'b0;
      if (w >= 0) run_job(w);
    end

    // Reset in the middle of RUN, then a normal job with requester 0 favoured again.
    set_req(0, 1'b1, 10, 12, 108); v[0] = 1'b1;
    wait_grant(w);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      drive_beat(1'b1, 1'b1, 1'b0);
    end
    @(negedge aclk);
    clear_beats();
    areset = 1'b1;
    v[0] = 1'b1; v[1] = 1'b1;
    #1;
    check("midrun_reset_ctrl", {24'b0, r0, r1, d0, d1, err, busy, rw, addr_reload}, 0);
    check("midrun_reset_addr", {8'b0, bsa, bba}, 0);
    abort_job();
    repeat (3) @(negedge aclk);
    v[0] = 1'b0; v[1] = 1'b0;
    areset = 1'b0;
    set_req(0, 1'b0, 2, 2, 36);
    set_req(1, 1'b1, 5, 5, 36);
    v[0] = 1'b1; v[1] = 1'b1;
    wait_grant(w);
    v[0] = 1'b0; v[1] = 1'b0;
    if (w >= 0) run_job(w);

    // Job that never receives a beat.
    set_req(1, 1'b0, 5, 5, 0); v[1] = 1'b1;
    wait_grant(w);
    #1;
`ifdef SCHED_TIMEOUT_EN
    n = 0;
    while (!d1 && n < 60) begin
      @(negedge aclk); #1; n++;
    end
    check("timeout_latency", n, 18);
`else
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk); #1;
      if (d0 || d1) seen = 1'b1;
    end
    check("no_timeout_busy", {31'b0, busy}, 1);
    check("no_timeout_done", {31'b0, seen}, 0);
    areset = 1'b1;
    abort_job();
    @(negedge aclk);
    areset = 1'b0;
`endif

    repeat (4) @(negedge aclk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
